unproject_viewport_to_world: RTL and testbench
==============================================

// Module: unproject_viewport_to_world
// PURPOSE
//  Inverse of the vertex projection stage: maps (viewport_x, viewport_y, z_depth) back to a world point.
//  Computes P = C + xc*u + yc*v + z*n, with xc = ((vx-VW/2)*z)>>>FOCAL_SHIFT and yc = ((vy-VH/2)*z)>>>FOCAL_SHIFT.
//  Used for picking and depth-buffer reconstruction. Fully pipelined, valid/ready on both sides, accepts 1 point/cycle.
// PARAMETERS
//  C_WIDTH=18 camera-centre width (signed, same units as P) | P_WIDTH=16 output world-point width (signed)
//  V_WIDTH=16 u/v/n component width (signed Q.FRAC_BITS) | FRAC_BITS=14 fraction bits of u/v/n
//  ZWIDTH=16 depth width (unsigned, world units) | FOCAL_SHIFT=8 log2 pixels per unit at depth 1
//  VW_OVER_TWO=320, VH_OVER_TWO=240 viewport half-extents | VIEWPORT_W_POSITION_WIDTH=20, VIEWPORT_H_POSITION_WIDTH=18
// PORTS
//  clk_in         in   1             system clock
//  rst_n_in       in   1             asynchronous active-low reset
//  valid_in       in   1             input point valid
//  ready_out      out  1             block can accept this cycle
//  viewport_x_in  in   VIEWPORT_W_POSITION_WIDTH   pixel column, unsigned
//  viewport_y_in  in   VIEWPORT_H_POSITION_WIDTH   pixel row, unsigned
//  z_depth_in     in   ZWIDTH        depth along n
//  C              in   3xC_WIDTH     camera position [x,y,z], signed
//  u, v, n        in   3xV_WIDTH     camera basis, signed Q.FRAC_BITS
//  valid_out      out  1             P_out valid
//  ready_in       in   1             downstream accepts
//  P_out          out  3xP_WIDTH     world point [x,y,z], signed, saturated
//  sat_out        out  1             some component of P_out saturated (qualified by valid_out)
//  busy_out       out  1             any pipeline stage holds a valid item
// BEHAVIOUR
//  Reset: valid_out=0, sat_out=0, busy_out=0, P_out=0, all stage-valid bits cleared. ready_out=1 after reset.
//  Handshake: transfer in when valid_in&&ready_out; out when valid_out&&ready_in. P_out/sat_out stable while valid_out&&!ready_in.
//  Stall: advance = !valid_out || ready_in. All 4 stages shift on advance, else hold. ready_out = advance (combinational).
//  Latency: 4 cycles accept->valid_out with no backpressure; throughput 1/cycle.
//  S1: dx = $signed({1'b0,vx}) - VW_OVER_TWO, dy likewise (width+1 signed). Register z.
//  S2: xc = (dx*z)>>>FOCAL_SHIFT, yc likewise (arithmetic shift, truncation toward -inf).
//  S3: per axis i: t = xc*u[i] + yc*v[i] + z*n[i] at full width, then >>>FRAC_BITS.
//  S4: s = t + C[i] (+2 guard bits); clamp to [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1]; sat_out = OR of clamp events.
//  C,u,v,n are not registered per item: they must stay stable while busy_out=1. Violation leaves results undefined but does not hang the block.
//  Bubble handling: a stage with valid=0 is overwritten on advance even if downstream stalls (no bubble squashing required).
//  Reset mid-operation: all in-flight items are discarded and valid_out drops to 0 on the same edge.
//  Simultaneous in/out on a full pipe with ready_in=1: both transfers happen, occupancy unchanged.
// CONFIGURATION
//  UNPROJECT_BOUNDS_CHECK_EN defined: an input with vx >= 2*VW_OVER_TWO or vy >= 2*VH_OVER_TWO is accepted but dropped at S1 (its valid bit is cleared). reject_out (out, 1) pulses for one cycle on acceptance.
//  Not defined: no reject_out port; all inputs are processed and out-of-range results rely on saturation.
// STRUCTURE
//  Package unproject_pkg: localparams DX_WIDTH, XC_WIDTH, TERM_WIDTH, SUM_WIDTH; typedef vec3_p_t; function sat_p().
//  Sub-module unproject_axis_mac (S3+S4 for one axis, with stall enable), instantiated 3x. Top holds S1/S2, valid chain, handshake.
// TESTING (FRAC_BITS=14, FOCAL_SHIFT=8, u=(16384,0,0), v=(0,16384,0), n=(0,0,16384), C=0 unless noted)
//  centre: vx=320, vy=240, z=100 -> P_out=(0,0,100) after 4 cycles, sat_out=0.
//  offset: vx=330, vy=230, z=256, C=(5,-3,7) -> P_out=(15,-13,263).
//  backpressure: 6 back-to-back inputs, ready_in low cycles 3-8 -> ready_out low while stalled; outputs in order, none lost or duplicated.
//  saturation: vx=0, vy=240, z=65535, C=(-32000,0,0) -> P_out.x=-32768, sat_out=1.
//  reset: assert rst_n_in with 3 items in flight -> valid_out=0 and busy_out=0 immediately; no stale output after release.
//  bounds (macro on): vx=640 -> reject_out pulses once, no valid_out; with macro off -> result emitted.

Source files
------------

// File: rtl/unproject_pkg.sv
// Shared widths, types and the output clamp for the viewport-to-world unprojection.
// Latency: n/a (declarations and one combinational helper function).
// Backpressure: n/a.
package unproject_pkg;

  // Base widths of the datapath
  localparam int C_WIDTH                   = 18;
  localparam int P_WIDTH                   = 16;
  localparam int V_WIDTH                   = 16;
  localparam int FRAC_BITS                 = 14;
  localparam int ZWIDTH                    = 16;
  localparam int FOCAL_SHIFT               = 8;
  localparam int VIEWPORT_W_POSITION_WIDTH = 20;
  localparam int VIEWPORT_H_POSITION_WIDTH = 18;

  // Centred pixel offset; the row offset is sign-extended into the wider column width
  localparam int DX_WIDTH      = VIEWPORT_W_POSITION_WIDTH + 1;
  // dx * z with z zero-extended to a signed operand
  localparam int PROD_WIDTH    = DX_WIDTH + ZWIDTH + 1;
  // Camera-space x/y after the focal shift
  localparam int XC_WIDTH      = PROD_WIDTH - FOCAL_SHIFT;
  // xc*u + yc*v + z*n: widest product plus two bits of growth for the three-way sum
  localparam int TERM_WIDTH    = XC_WIDTH + V_WIDTH + 2;
  // Term after removing the basis fraction bits
  localparam int SHIFTED_WIDTH = TERM_WIDTH - FRAC_BITS;
  // Term plus camera centre, with two guard bits
  localparam int SUM_WIDTH     = SHIFTED_WIDTH + 2;

  localparam logic signed [SUM_WIDTH-1:0] P_MAX_S = SUM_WIDTH'((2 ** (P_WIDTH - 1)) - 1);
  localparam logic signed [SUM_WIDTH-1:0] P_MIN_S = SUM_WIDTH'(-(2 ** (P_WIDTH - 1)));

  // World point, component 0 (x) in the least significant slice
  typedef logic [2:0][P_WIDTH-1:0] vec3_p_t;

  typedef struct packed {
    logic                      sat;
    logic signed [P_WIDTH-1:0] val;
  } sat_res_t;

  // Clamp a guarded sum into the signed output range, flagging any clamp
  function automatic sat_res_t sat_p(input logic signed [SUM_WIDTH-1:0] s);
    sat_res_t r;
    r.sat = 1'b0;
    r.val = s[P_WIDTH-1:0];
    if (s > P_MAX_S) begin
      r.sat = 1'b1;
      r.val = {1'b0, {(P_WIDTH-1){1'b1}}};
    end else if (s < P_MIN_S) begin
      r.sat = 1'b1;
      r.val = {1'b1, {(P_WIDTH-1){1'b0}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/unproject_viewport_to_world_axis_mac.sv
// One world axis: basis multiply-accumulate (S3) then centre add and clamp (S4).
// Latency: 2 cycles, both stages move only when en is high.
// Backpressure: en low holds both stage registers unchanged.
module unproject_axis_mac
  import unproject_pkg::*;
(
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       en,
  input  logic signed [XC_WIDTH-1:0] xc,
  input  logic signed [XC_WIDTH-1:0] yc,
  input  logic        [ZWIDTH-1:0]   z,
  input  logic signed [V_WIDTH-1:0]  u_i,
  input  logic signed [V_WIDTH-1:0]  v_i,
  input  logic signed [V_WIDTH-1:0]  n_i,
  input  logic signed [C_WIDTH-1:0]  c_i,
  output logic signed [P_WIDTH-1:0]  p,
  output logic                       sat
);

  logic signed [ZWIDTH:0]          z_s;
  logic signed [TERM_WIDTH-1:0]    term_u;
  logic signed [TERM_WIDTH-1:0]    term_v;
  logic signed [TERM_WIDTH-1:0]    term_n;
  logic signed [TERM_WIDTH-1:0]    t_full;
  logic signed [TERM_WIDTH-1:0]    t_asr;
  logic signed [SHIFTED_WIDTH-1:0] t_q;
  logic signed [SUM_WIDTH-1:0]     sum;
  sat_res_t                        clamp;

  // Operands are sign-extended to the full term width so no product bits are lost
  assign z_s    = $signed({1'b0, z});
  assign term_u = TERM_WIDTH'(xc)  * TERM_WIDTH'(u_i);
  assign term_v = TERM_WIDTH'(yc)  * TERM_WIDTH'(v_i);
  assign term_n = TERM_WIDTH'(z_s) * TERM_WIDTH'(n_i);
  assign t_full = term_u + term_v + term_n;
  assign t_asr  = t_full >>> FRAC_BITS;

  assign sum    = SUM_WIDTH'(t_q) + SUM_WIDTH'(c_i);
  assign clamp  = sat_p(sum);

  // S3: register the accumulated axis term with the basis fraction removed
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      t_q <= '0;
    end else if (en) begin
      t_q <= t_asr[SHIFTED_WIDTH-1:0];
    end
  end

  // S4: register the clamped world coordinate and its clamp flag
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      p   <= '0;
      sat <= 1'b0;
    end else if (en) begin
      p   <= clamp.val;
      sat <= clamp.sat;
    end
  end

endmodule

// File: rtl/unproject_viewport_to_world.sv
// Maps (viewport_x, viewport_y, depth) back to a saturated world point P = C + xc*u + yc*v + z*n.
// Latency: 4 cycles accept->valid_out, 1 point/cycle. Optional UNPROJECT_BOUNDS_CHECK_EN drops off-viewport inputs.
// Backpressure: whole 4-stage pipe freezes while valid_out && !ready_in; ready_out is that advance term.
module unproject_viewport_to_world
  import unproject_pkg::*;
#(
  parameter int VW_OVER_TWO = 320,
  parameter int VH_OVER_TWO = 240
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n_in,
  input  logic                                 valid_in,
  output logic                                 ready_out,
  input  logic [VIEWPORT_W_POSITION_WIDTH-1:0] viewport_x_in,
  input  logic [VIEWPORT_H_POSITION_WIDTH-1:0] viewport_y_in,
  input  logic [ZWIDTH-1:0]                    z_depth_in,
  input  logic [3*C_WIDTH-1:0]                 C,
  input  logic [3*V_WIDTH-1:0]                 u,
  input  logic [3*V_WIDTH-1:0]                 v,
  input  logic [3*V_WIDTH-1:0]                 n,
  output logic                                 valid_out,
  input  logic                                 ready_in,
  output logic [3*P_WIDTH-1:0]                 P_out,
  output logic                                 sat_out,
`ifdef UNPROJECT_BOUNDS_CHECK_EN
  output logic                                 reject_out,
`endif
  output logic                                 busy_out
);

  logic                         advance;
  logic                         s1_take;
  logic [4:1]                   vld_q;
  logic signed [DX_WIDTH-1:0]   dx_d;
  logic signed [DX_WIDTH-1:0]   dy_d;
  logic signed [DX_WIDTH-1:0]   dx_q;
  logic signed [DX_WIDTH-1:0]   dy_q;
  logic        [ZWIDTH-1:0]     z1_q;
  logic        [ZWIDTH-1:0]     z2_q;
  logic signed [ZWIDTH:0]       z1_s;
  logic signed [PROD_WIDTH-1:0] prod_x;
  logic signed [PROD_WIDTH-1:0] prod_y;
  logic signed [PROD_WIDTH-1:0] shx;
  logic signed [PROD_WIDTH-1:0] shy;
  logic signed [XC_WIDTH-1:0]   xc_q;
  logic signed [XC_WIDTH-1:0]   yc_q;
  vec3_p_t                      p_vec;
  logic [2:0]                   sat_vec;

  // A stage may be overwritten whenever the output slot is empty or being drained
  assign advance   = !valid_out || ready_in;
  assign ready_out = advance;
  assign valid_out = vld_q[4];
  assign busy_out  = |vld_q;

`ifdef UNPROJECT_BOUNDS_CHECK_EN
  localparam logic [VIEWPORT_W_POSITION_WIDTH-1:0] VX_LIMIT = VIEWPORT_W_POSITION_WIDTH'(2 * VW_OVER_TWO);
  localparam logic [VIEWPORT_H_POSITION_WIDTH-1:0] VY_LIMIT = VIEWPORT_H_POSITION_WIDTH'(2 * VH_OVER_TWO);
  logic in_range;
  assign in_range = (viewport_x_in < VX_LIMIT) && (viewport_y_in < VY_LIMIT);
  // Off-viewport points are still handshaken in, but never become a valid S1 item
  assign s1_take  = valid_in && in_range;

  // One-cycle flag for every accepted-but-dropped point
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      reject_out <= 1'b0;
    end else begin
      reject_out <= advance && valid_in && !in_range;
    end
  end
`else
  assign s1_take  = valid_in;
`endif

  // Pixel coordinates are unsigned; centre them as signed offsets from the viewport middle
  assign dx_d = $signed(DX_WIDTH'(viewport_x_in)) - $signed(DX_WIDTH'(VW_OVER_TWO));
  assign dy_d = $signed(DX_WIDTH'(viewport_y_in)) - $signed(DX_WIDTH'(VH_OVER_TWO));

  // Perspective scale: offset grows linearly with depth, floor-rounded by the arithmetic shift
  assign z1_s   = $signed({1'b0, z1_q});
  assign prod_x = PROD_WIDTH'(dx_q) * PROD_WIDTH'(z1_s);
  assign prod_y = PROD_WIDTH'(dy_q) * PROD_WIDTH'(z1_s);
  assign shx    = prod_x >>> FOCAL_SHIFT;
  assign shy    = prod_y >>> FOCAL_SHIFT;

  // Stage valid chain: shifts as a unit on advance, bubbles are simply overwritten
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_q <= '0;
    end else if (advance) begin
      vld_q <= {vld_q[3:1], s1_take};
    end
  end

  // S1: centred offsets and depth
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dx_q <= '0;
      dy_q <= '0;
      z1_q <= '0;
    end else if (advance) begin
      dx_q <= dx_d;
      dy_q <= dy_d;
      z1_q <= z_depth_in;
    end
  end

  // S2: camera-space x/y, depth carried along for the n term
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      xc_q <= '0;
      yc_q <= '0;
      z2_q <= '0;
    end else if (advance) begin
      xc_q <= shx[XC_WIDTH-1:0];
      yc_q <= shy[XC_WIDTH-1:0];
      z2_q <= z1_q;
    end
  end

  // S3/S4 per world axis; basis and centre are read live and must be held while busy
  for (genvar i = 0; i < 3; i++) begin : g_axis
    unproject_axis_mac u_mac (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .en       (advance),
      .xc       (xc_q),
      .yc       (yc_q),
      .z        (z2_q),
      .u_i      ($signed(u[i*V_WIDTH +: V_WIDTH])),
      .v_i      ($signed(v[i*V_WIDTH +: V_WIDTH])),
      .n_i      ($signed(n[i*V_WIDTH +: V_WIDTH])),
      .c_i      ($signed(C[i*C_WIDTH +: C_WIDTH])),
      .p        (p_vec[i]),
      .sat      (sat_vec[i])
    );
  end

  assign P_out   = p_vec;
  assign sat_out = valid_out && (|sat_vec);

endmodule

// File: tb/tb_unproject_viewport_to_world.sv
// Scoreboard bench for unproject_viewport_to_world: a behavioural model queues expected points at
// input handshake and the queue is popped and compared at output handshake.
// Also build with +define+UNPROJECT_BOUNDS_CHECK_EN to cover the reject path.
module tb_unproject_viewport_to_world;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        valid_in;
  logic        ready_out;
  logic [19:0] viewport_x_in;
  logic [17:0] viewport_y_in;
  logic [15:0] z_depth_in;
  logic [53:0] C;
  logic [47:0] u, v, n;
  logic        valid_out;
  logic        ready_in;
  logic [47:0] P_out;
  logic        sat_out;
  logic        busy_out;
`ifdef UNPROJECT_BOUNDS_CHECK_EN
  logic        reject_out;
`endif

  always #5 clk_in = ~clk_in;

  unproject_viewport_to_world dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .viewport_x_in (viewport_x_in),
    .viewport_y_in (viewport_y_in),
    .z_depth_in    (z_depth_in),
    .C             (C),
    .u             (u),
    .v             (v),
    .n             (n),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .P_out         (P_out),
    .sat_out       (sat_out),
`ifdef UNPROJECT_BOUNDS_CHECK_EN
    .reject_out    (reject_out),
`endif
    .busy_out      (busy_out)
  );

  typedef struct {
    logic [47:0] p;
    logic        sat;
    int          acc_cyc;
    bit          lat_ok;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  bit   lat_mode    = 1'b1;
  bit   rej_pend    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint comp(input logic [47:0] vec, input int i);
    logic signed [15:0] c16;
    c16 = vec[i*16 +: 16];
    return longint'(c16);
  endfunction

  // Reference arithmetic straight from the unprojection formula, in 64-bit integers
  function automatic exp_t model(input longint vx, input longint vy, input longint z);
    exp_t   e;
    longint dx, dy, xc, yc, t, s, ci;
    logic signed [17:0] c18;
    dx = vx - 320;
    dy = vy - 240;
    xc = (dx * z) >>> 8;
    yc = (dy * z) >>> 8;
    e.sat = 1'b0;
    e.p   = '0;
    for (int i = 0; i < 3; i++) begin
      c18 = C[i*18 +: 18];
      ci  = longint'(c18);
      t = (xc * comp(u, i) + yc * comp(v, i) + z * comp(n, i)) >>> 14;
      s = t + ci;
      if (s > 32767) begin
        s = 32767;
        e.sat = 1'b1;
      end else if (s < -32768) begin
        s = -32768;
        e.sat = 1'b1;
      end
      e.p[i*16 +: 16] = 16'(s);
    end
    e.acc_cyc = 0;
    e.lat_ok  = 1'b0;
    return e;
  endfunction

  function automatic logic [53:0] pack_c(input int x, input int y, input int z);
    return {18'(z), 18'(y), 18'(x)};
  endfunction

  function automatic logic [47:0] pack_v(input int x, input int y, input int z);
    return {16'(z), 16'(y), 16'(x)};
  endfunction

  // One cycle: sample #1 after the falling edge, score both handshakes, wait for next falling edge
  task automatic step(output bit acc);
    exp_t e;
    #1;
    acc = valid_in && ready_out;
`ifdef UNPROJECT_BOUNDS_CHECK_EN
    chk("reject_out", reject_out, rej_pend);
    rej_pend = 1'b0;
`endif
    chk("ready_vs_stall", ready_out, !(valid_out && !ready_in));
    if (valid_out && ready_in) begin
      if (q.size() == 0) begin
        chk("spurious_out", valid_out, 1'b0);
      end else begin
        e = q.pop_front();
        chk("P_out", P_out, e.p);
        chk("sat_out", sat_out, e.sat);
        if (e.lat_ok) chk("latency", cyc - e.acc_cyc, 4);
      end
    end
    if (acc) begin
      e = model(viewport_x_in, viewport_y_in, z_depth_in);
      e.acc_cyc = cyc;
      e.lat_ok  = lat_mode;
`ifdef UNPROJECT_BOUNDS_CHECK_EN
      if (viewport_x_in >= 640 || viewport_y_in >= 480) rej_pend = 1'b1;
      else q.push_back(e);
`else
      q.push_back(e);
`endif
    end
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic send(input int vx, input int vy, input int z);
    bit acc;
    valid_in      = 1'b1;
    viewport_x_in = 20'(vx);
    viewport_y_in = 18'(vy);
    z_depth_in    = 16'(z);
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) step(acc);
    if (!acc) chk("accept_timeout", 64'(acc), 64'(1));
    valid_in = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int k;
    valid_in = 1'b0;
    ready_in = 1'b1;
    k = 0;
    while ((q.size() != 0 || busy_out) && k < 40) begin
      step(acc);
      k++;
    end
    chk("drain_left", q.size(), 0);
    chk("busy_idle", busy_out, 1'b0);
  endtask

  task automatic identity_basis();
    u = pack_v(16384, 0, 0);
    v = pack_v(0, 16384, 0);
    n = pack_v(0, 0, 16384);
  endtask

  initial begin
    bit acc;
    int sent;
    rst_n_in      = 1'b0;
    valid_in      = 1'b0;
    ready_in      = 1'b1;
    viewport_x_in = '0;
    viewport_y_in = '0;
    z_depth_in    = '0;
    C             = '0;
    identity_basis();

    // Reset state
    @(negedge clk_in);
    #1;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_busy_out", busy_out, 1'b0);
    chk("rst_sat_out", sat_out, 1'b0);
    chk("rst_P_out", P_out, 48'h0);
    chk("rst_ready_out", ready_out, 1'b1);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Centre pixel and offset with camera centre
    send(320, 240, 100);
    drain();
    C = pack_c(5, -3, 7);
    send(330, 230, 256);
    drain();

    // Saturation on x
    C = pack_c(-32000, 0, 0);
    send(0, 240, 65535);
    drain();

    // Right edge pixel: dropped with the bounds check, otherwise processed
    C = '0;
    send(640, 240, 10);
    drain();

    // Backpressure: six back-to-back points, sink stalls on cycles 3..8
    lat_mode = 1'b0;
    sent = 0;
    for (int c = 0; c < 40 && (sent < 6 || c < 9); c++) begin
      valid_in      = (sent < 6);
      viewport_x_in = 20'(300 + 7 * sent);
      viewport_y_in = 18'(200 + 11 * sent);
      z_depth_in    = 16'(50 + 100 * sent);
      ready_in      = !(c >= 3 && c <= 8);
      step(acc);
      if (acc) sent++;
    end
    chk("bp_sent", sent, 6);
    drain();

    // Random traffic with a non-trivial basis and centre, random source and sink gaps
    C = pack_c(int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000);
    u = pack_v(int'($urandom_range(32768)) - 16384, int'($urandom_range(32768)) - 16384, int'($urandom_range(32768)) - 16384);
    v = pack_v(int'($urandom_range(32768)) - 16384, int'($urandom_range(32768)) - 16384, int'($urandom_range(32768)) - 16384);
    n = pack_v(int'($urandom_range(32768)) - 16384, int'($urandom_range(32768)) - 16384, int'($urandom_range(32768)) - 16384);
    for (int c = 0; c < 80; c++) begin
      valid_in      = ($urandom_range(3) != 0);
      ready_in      = ($urandom_range(2) != 0);
      viewport_x_in = 20'($urandom_range(639));
      viewport_y_in = 18'($urandom_range(479));
      z_depth_in    = 16'($urandom_range(3000));
      step(acc);
    end
    drain();

    // Reset with three points in flight
    C = '0;
    identity_basis();
    lat_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid_in      = 1'b1;
      viewport_x_in = 20'(310 + k);
      viewport_y_in = 18'(250 - k);
      z_depth_in    = 16'(400 + k);
      step(acc);
    end
    valid_in = 1'b0;
    chk("inflight_busy", busy_out, 1'b1);
    rst_n_in = 1'b0;
    #1;
    chk("midrst_valid_out", valid_out, 1'b0);
    chk("midrst_busy_out", busy_out, 1'b0);
    q.delete();
    rej_pend = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    for (int k = 0; k < 8; k++) step(acc);
    chk("post_rst_busy", busy_out, 1'b0);

    // Pipe still works after the reset
    send(321, 239, 512);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
